// File: rtl/matmul_sequencer.sv
// matmul_sequencer: cycle-level control for P = X*A. It streams X in, steps the
// ROM and accumulator through each dot product, writes every result to RAM and
// can optionally read the results back out.
// Optional feature macro: READOUT_EN adds the READ sweep of the result RAM.
module matmul_sequencer #(
  parameter int N_ROW = 2,
  parameter int N_MUL = 4,
  parameter int N_COL = 4,
  localparam int ROM_AW = (N_MUL * N_COL > 1) ? $clog2(N_MUL * N_COL) : 1,
  localparam int XS_W   = (N_ROW * N_MUL > 1) ? $clog2(N_ROW * N_MUL) : 1,
  localparam int CM_W   = $clog2(N_MUL) + 1,
  localparam int RAM_AW = (N_ROW * N_COL > 1) ? $clog2(N_ROW * N_COL) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              valid_input,
  output logic              input_load_en,
  output logic              xload_done,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [XS_W-1:0]   x_sel,
  output logic [CM_W-1:0]   count_mul,
  output logic              alu_en,
  output logic              acc_clr,
  output logic              ram_en,
  output logic              web,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              out_valid,
  output logic              busy,
  output logic              finish
);

  localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, MUL, DRAIN, WRITE, READ, DONE
  } state_t;

  state_t state_q, state_d;
  logic [XS_W-1:0]   load_q, load_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CM_W-1:0]   k_q, k_d;
`ifdef READOUT_EN
  logic [RAM_AW-1:0] rd_q, rd_d;
`endif

  logic              input_load_en_q, input_load_en_d;
  logic              rom_en_q, rom_en_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [XS_W-1:0]   x_sel_q, x_sel_d;
  logic [CM_W-1:0]   count_mul_q, count_mul_d;
  logic              alu_en_q, alu_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic              ram_en_q, ram_en_d;
  logic              web_q, web_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;

  // Next state and loop counters: load count, then nested row/col/k walk.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
`ifdef READOUT_EN
    rd_d    = rd_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = LOAD;
          load_d  = '0;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
`ifdef READOUT_EN
          rd_d    = '0;
`endif
        end
      end
      LOAD: begin
        if (valid_input) begin
          if (load_q == XS_W'(N_ROW * N_MUL - 1)) begin
            state_d = MUL;
            load_d  = '0;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
          end else begin
            load_d = load_q + XS_W'(1);
          end
        end
      end
      MUL: begin
        if (k_q == CM_W'(N_MUL - 1)) state_d = DRAIN;
        else                         k_d = k_q + CM_W'(1);
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        k_d = '0;
        if (col_q == COL_W'(N_COL - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(N_ROW - 1)) begin
            row_d = '0;
`ifdef READOUT_EN
            rd_d    = '0;
            state_d = READ;
`else
            state_d = DONE;
`endif
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = MUL;
          end
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = MUL;
        end
      end
`ifdef READOUT_EN
      READ: begin
        if (rd_q == RAM_AW'(N_ROW * N_COL - 1)) begin
          rd_d    = '0;
          state_d = DONE;
        end else begin
          rd_d = rd_q + RAM_AW'(1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    input_load_en_d = (state_d == LOAD);
    rom_en_d        = (state_d == MUL);
    rom_addr_d      = '0;
    x_sel_d         = '0;
    count_mul_d     = '0;
    if (state_d == MUL) begin
      rom_addr_d  = ROM_AW'(int'(k_d) * N_COL + int'(col_d));
      x_sel_d     = XS_W'(int'(row_d) * N_MUL + int'(k_d));
      count_mul_d = k_d;
    end
    // ROM data arrives one cycle after its strobe.
    alu_en_d    = rom_en_q;
    acc_clr_d   = rom_en_q && (count_mul_q == '0);
    ram_en_d    = (state_d == WRITE);
    web_d       = (state_d != WRITE);
    ram_addr_d  = '0;
    if (state_d == WRITE) ram_addr_d = RAM_AW'(int'(row_d) * N_COL + int'(col_d));
`ifdef READOUT_EN
    if (state_d == READ) begin
      ram_en_d   = 1'b1;
      ram_addr_d = rd_d;
    end
    out_valid_d = ram_en_q && web_q;
`else
    out_valid_d = 1'b0;
`endif
    busy_d   = (state_d != IDLE);
    finish_d = (state_d == DONE);
  end

  // State, counters and output registers; reset dominates every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      load_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      k_q             <= '0;
`ifdef READOUT_EN
      rd_q            <= '0;
`endif
      input_load_en_q <= 1'b0;
      rom_en_q        <= 1'b0;
      rom_addr_q      <= '0;
      x_sel_q         <= '0;
      count_mul_q     <= '0;
      alu_en_q        <= 1'b0;
      acc_clr_q       <= 1'b0;
      ram_en_q        <= 1'b0;
      web_q           <= 1'b1;
      ram_addr_q      <= '0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      finish_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      load_q          <= load_d;
      row_q           <= row_d;
      col_q           <= col_d;
      k_q             <= k_d;
`ifdef READOUT_EN
      rd_q            <= rd_d;
`endif
      input_load_en_q <= input_load_en_d;
      rom_en_q        <= rom_en_d;
      rom_addr_q      <= rom_addr_d;
      x_sel_q         <= x_sel_d;
      count_mul_q     <= count_mul_d;
      alu_en_q        <= alu_en_d;
      acc_clr_q       <= acc_clr_d;
      ram_en_q        <= ram_en_d;
      web_q           <= web_d;
      ram_addr_q      <= ram_addr_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
      finish_q        <= finish_d;
    end
  end

  // Last-byte acceptance is flagged in the cycle the byte is presented.
  assign xload_done    = (state_q == LOAD) && valid_input &&
                         (load_q == XS_W'(N_ROW * N_MUL - 1));
  assign input_load_en = input_load_en_q;
  assign rom_en        = rom_en_q;
  assign rom_addr      = rom_addr_q;
  assign x_sel         = x_sel_q;
  assign count_mul     = count_mul_q;
  assign alu_en        = alu_en_q;
  assign acc_clr       = acc_clr_q;
  assign ram_en        = ram_en_q;
  assign web           = web_q;
  assign ram_addr      = ram_addr_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign finish        = finish_q;

endmodule
